// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: arbitrates EX and LSU onto the
// single write port and tracks outstanding loads for issue hazards.
module regfile_wb_scheduler #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_issue_vld,
  input  logic [4:0]  i_issue_rs1,
  input  logic [4:0]  i_issue_rs2,
  input  logic        i_issue_use_rs1,
  input  logic        i_issue_use_rs2,
  input  logic [4:0]  i_issue_rd,
  input  logic        i_issue_wr,
  input  logic        i_issue_is_load,
  output logic        o_issue_stall,
  input  logic        i_ex_vld,
  input  logic [4:0]  i_ex_addr,
  input  logic [31:0] i_ex_data,
  output logic        o_ex_rdy,
  input  logic        i_lsu_vld,
  input  logic [4:0]  i_lsu_addr,
  input  logic [31:0] i_lsu_data,
  output logic        o_lsu_rdy,
  output logic        o_rd_wren,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic [31:0] o_pending,
  output logic        o_err
);

  logic             r_ptr_lsu;
  logic             r_lsu_wb;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_pending;
  logic             r_rd_wren;
  logic [4:0]       r_rd_addr;
  logic [31:0]      r_rd_data;
  logic             r_err;

  logic             w_gnt_ex;
  logic             w_gnt_lsu;
  logic             w_contested;
  logic [4:0]       w_wb_addr;
  logic [31:0]      w_wb_data;
  logic             w_hit_rs1;
  logic             w_hit_rs2;
  logic             w_hit_rd;
  logic             w_full;
  logic             w_stall;
  logic             w_load_acc;
  logic             w_commit_ok;
  logic             w_commit_bad;
  logic [31:0]      w_pend_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Round-robin arbitration; pointer names the source that wins a tie.
  always_comb begin
    w_contested = i_ex_vld & i_lsu_vld;
    w_gnt_ex    = i_ex_vld & (~i_lsu_vld | ~r_ptr_lsu);
    w_gnt_lsu   = i_lsu_vld & (~i_ex_vld | r_ptr_lsu);
    w_wb_addr   = i_ex_addr;
    w_wb_data   = i_ex_data;
    if (w_gnt_lsu) begin
      w_wb_addr = i_lsu_addr;
      w_wb_data = i_lsu_data;
    end
  end

  // Issue hazard detection against outstanding loads.
  always_comb begin
    w_hit_rs1  = i_issue_use_rs1 & (i_issue_rs1 != 5'd0)
               & r_pending[i_issue_rs1];
    w_hit_rs2  = i_issue_use_rs2 & (i_issue_rs2 != 5'd0)
               & r_pending[i_issue_rs2];
    w_hit_rd   = i_issue_wr & (i_issue_rd != 5'd0)
               & r_pending[i_issue_rd];
    w_full     = (r_cnt == CNT_W'(MAX_OUTSTANDING));
    w_stall    = i_issue_vld & (w_hit_rs1 | w_hit_rs2 | w_hit_rd
               | (i_issue_is_load & w_full));
    w_load_acc = i_issue_vld & ~w_stall & i_issue_is_load
               & i_issue_wr & (i_issue_rd != 5'd0);
  end

  // Scoreboard next state: LSU commit clears, accepted load sets.
  always_comb begin
    w_commit_ok  = r_lsu_wb & r_pending[r_rd_addr] & (r_cnt != '0);
    w_commit_bad = r_lsu_wb & ~w_commit_ok;
    w_pend_nxt   = r_pending;
    if (r_lsu_wb) begin
      w_pend_nxt[r_rd_addr] = 1'b0;
    end
    if (w_load_acc) begin
      w_pend_nxt[i_issue_rd] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
    w_cnt_nxt = r_cnt;
    unique case ({w_load_acc, w_commit_ok})
      2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Write port, arbitration pointer and scoreboard state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr_lsu <= 1'b0;
      r_lsu_wb  <= 1'b0;
      r_cnt     <= '0;
      r_pending <= '0;
      r_rd_wren <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_contested) begin
        r_ptr_lsu <= ~r_ptr_lsu;
      end
      if (w_gnt_ex | w_gnt_lsu) begin
        r_rd_addr <= w_wb_addr;
        r_rd_data <= w_wb_data;
      end
      r_rd_wren <= (w_gnt_ex | w_gnt_lsu) & (w_wb_addr != 5'd0);
      r_lsu_wb  <= w_gnt_lsu & (w_wb_addr != 5'd0);
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pend_nxt;
      if (w_commit_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_issue_stall = w_stall;
  assign o_ex_rdy      = w_gnt_ex;
  assign o_lsu_rdy     = w_gnt_lsu;
  assign o_rd_wren     = r_rd_wren;
  assign o_rd_addr     = r_rd_addr;
  assign o_rd_data     = r_rd_data;
  assign o_pending     = r_pending;
  assign o_err         = r_err;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed vectors, corner sequences
// and a random run against a behavioural scoreboard model.
module tb_regfile_wb_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_issue_vld;
  logic [4:0]  i_issue_rs1;
  logic [4:0]  i_issue_rs2;
  logic        i_issue_use_rs1;
  logic        i_issue_use_rs2;
  logic [4:0]  i_issue_rd;
  logic        i_issue_wr;
  logic        i_issue_is_load;
  logic        o_issue_stall;
  logic        i_ex_vld;
  logic [4:0]  i_ex_addr;
  logic [31:0] i_ex_data;
  logic        o_ex_rdy;
  logic        i_lsu_vld;
  logic [4:0]  i_lsu_addr;
  logic [31:0] i_lsu_data;
  logic        o_lsu_rdy;
  logic        o_rd_wren;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic [31:0] o_pending;
  logic        o_err;

  int total = 0;
  int bad = 0;

  always #5 i_clk = ~i_clk;

  regfile_wb_scheduler dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_issue_vld(i_issue_vld),
    .i_issue_rs1(i_issue_rs1), .i_issue_rs2(i_issue_rs2),
    .i_issue_use_rs1(i_issue_use_rs1),
    .i_issue_use_rs2(i_issue_use_rs2),
    .i_issue_rd(i_issue_rd), .i_issue_wr(i_issue_wr),
    .i_issue_is_load(i_issue_is_load),
    .o_issue_stall(o_issue_stall),
    .i_ex_vld(i_ex_vld), .i_ex_addr(i_ex_addr),
    .i_ex_data(i_ex_data), .o_ex_rdy(o_ex_rdy),
    .i_lsu_vld(i_lsu_vld), .i_lsu_addr(i_lsu_addr),
    .i_lsu_data(i_lsu_data), .o_lsu_rdy(o_lsu_rdy),
    .o_rd_wren(o_rd_wren), .o_rd_addr(o_rd_addr),
    .o_rd_data(o_rd_data), .o_pending(o_pending),
    .o_err(o_err)
  );

  typedef struct {
    logic       vld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       exp_stall;
  } vec_t;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_issue_vld = 0; i_issue_rs1 = 0; i_issue_rs2 = 0;
    i_issue_use_rs1 = 0; i_issue_use_rs2 = 0;
    i_issue_rd = 0; i_issue_wr = 0; i_issue_is_load = 0;
    i_ex_vld = 0; i_ex_addr = 0; i_ex_data = 0;
    i_lsu_vld = 0; i_lsu_addr = 0; i_lsu_data = 0;
  endtask

  task automatic do_reset();
    idle();
    i_rst_n = 0;
    tick();
    tick();
    i_rst_n = 1;
  endtask

  task automatic set_load(input logic [4:0] rd);
    i_issue_vld = 1; i_issue_rd = rd; i_issue_wr = 1;
    i_issue_is_load = 1; i_issue_use_rs1 = 0;
    i_issue_use_rs2 = 0;
  endtask

  task automatic load_ok(input logic [4:0] rd, string nm);
    set_load(rd);
    #1;
    chk(nm, o_issue_stall, 0);
    tick();
    idle();
  endtask

  // Behavioural reference model
  bit          m_pend[32];
  int          m_cnt;
  bit          m_pref_lsu;
  bit          m_wv;
  bit          m_wl;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  bit          m_err;

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < 32; k++) v[k] = m_pend[k];
    return v;
  endfunction

  function automatic bit m_busy(logic [4:0] a);
    return (a != 0) && m_pend[a];
  endfunction

  function automatic bit m_stall();
    if (!i_issue_vld) return 0;
    if (i_issue_use_rs1 && m_busy(i_issue_rs1)) return 1;
    if (i_issue_use_rs2 && m_busy(i_issue_rs2)) return 1;
    if (i_issue_wr && m_busy(i_issue_rd)) return 1;
    if (i_issue_is_load && m_cnt == 4) return 1;
    return 0;
  endfunction

  vec_t vt[8];
  logic [4:0] ex_l[4];
  logic [4:0] ls_l[4];
  logic [4:0] exp_ord[8];
  logic [4:0] gq[$];
  logic [4:0] wq[$];
  int avail[$];

  initial begin
    i_rst_n = 0;
    idle();

    // Reset then EX write x5
    do_reset();
    chk("rst_wren", o_rd_wren, 0);
    chk("rst_addr", o_rd_addr, 0);
    chk("rst_data", o_rd_data, 0);
    chk("rst_pend", o_pending, 0);
    chk("rst_err", o_err, 0);
    i_ex_vld = 1; i_ex_addr = 5; i_ex_data = 32'hDEADBEEF;
    #1;
    chk("ex_rdy", o_ex_rdy, 1);
    tick();
    idle();
    #1;
    chk("ex_wren", o_rd_wren, 1);
    chk("ex_addr", o_rd_addr, 5);
    chk("ex_data", o_rd_data, 32'hDEADBEEF);
    chk("ex_pend", o_pending, 0);
    tick();
    chk("ex_wren_off", o_rd_wren, 0);

    // Load x7, dependent add, LSU return
    do_reset();
    load_ok(7, "ld7_stall");
    i_issue_vld = 1; i_issue_rs1 = 7; i_issue_use_rs1 = 1;
    i_issue_rd = 9; i_issue_wr = 1;
    #1;
    chk("raw_stall", o_issue_stall, 1);
    chk("raw_pend", o_pending, 32'h80);
    i_lsu_vld = 1; i_lsu_addr = 7; i_lsu_data = 32'h12;
    #1;
    chk("lsu_rdy", o_lsu_rdy, 1);
    tick();
    i_lsu_vld = 0;
    #1;
    chk("ld_wren", o_rd_wren, 1);
    chk("ld_addr", o_rd_addr, 7);
    chk("ld_data", o_rd_data, 32'h12);
    chk("ld_pend_k1", o_pending, 32'h80);
    chk("ld_stall_k1", o_issue_stall, 1);
    tick();
    chk("ld_pend_k2", o_pending, 0);
    chk("ld_stall_k2", o_issue_stall, 0);
    idle();

    // Table of stall vectors with x7 pending
    vt[0] = '{1, 7, 0, 1, 0, 8, 1, 1};
    vt[1] = '{1, 7, 0, 0, 0, 8, 1, 0};
    vt[2] = '{1, 3, 7, 0, 1, 8, 1, 1};
    vt[3] = '{1, 3, 4, 1, 1, 7, 1, 1};
    vt[4] = '{1, 3, 4, 1, 1, 7, 0, 0};
    vt[5] = '{0, 7, 7, 1, 1, 7, 1, 0};
    vt[6] = '{1, 0, 0, 1, 1, 0, 1, 0};
    vt[7] = '{1, 5, 6, 1, 1, 8, 1, 0};
    do_reset();
    load_ok(7, "tbl_ld7");
    for (int v = 0; v < 8; v++) begin
      i_issue_vld = vt[v].vld;
      i_issue_rs1 = vt[v].rs1;
      i_issue_rs2 = vt[v].rs2;
      i_issue_use_rs1 = vt[v].u1;
      i_issue_use_rs2 = vt[v].u2;
      i_issue_rd = vt[v].rd;
      i_issue_wr = vt[v].wr;
      i_issue_is_load = 0;
      #1;
      chk($sformatf("tbl_stall%0d", v), o_issue_stall,
          vt[v].exp_stall);
      tick();
    end
    idle();

    // Contested arbitration: alternate starting with EX
    do_reset();
    for (int k = 0; k < 4; k++) begin
      ex_l[k] = 5'(k + 1);
      ls_l[k] = 5'(k + 8);
      exp_ord[2*k] = 5'(k + 1);
      exp_ord[2*k+1] = 5'(k + 8);
      load_ok(5'(k + 8), "rr_ld");
    end
    begin
      int ei;
      int li;
      ei = 0;
      li = 0;
      gq.delete();
      wq.delete();
      for (int c = 0; c < 16; c++) begin
        if (o_rd_wren) wq.push_back(o_rd_addr);
        if (ei == 4 && li == 4) break;
        i_ex_vld = (ei < 4);
        i_ex_addr = ex_l[ei % 4];
        i_ex_data = 32'h100 + 32'(ei);
        i_lsu_vld = (li < 4);
        i_lsu_addr = ls_l[li % 4];
        i_lsu_data = 32'h200 + 32'(li);
        #1;
        if (o_ex_rdy && o_lsu_rdy) chk("rr_double", 1, 0);
        if (o_ex_rdy && i_ex_vld) begin
          gq.push_back(i_ex_addr);
          ei++;
        end
        if (o_lsu_rdy && i_lsu_vld) begin
          gq.push_back(i_lsu_addr);
          li++;
        end
        tick();
      end
      idle();
      chk("rr_ngrant", gq.size(), 8);
      chk("rr_nwrite", wq.size(), 8);
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("rr_g%0d", k),
            (k < gq.size()) ? gq[k] : 5'h1f, exp_ord[k]);
        chk($sformatf("rr_w%0d", k),
            (k < wq.size()) ? wq[k] : 5'h1f, exp_ord[k]);
      end
      tick();
      chk("rr_pend", o_pending, 0);
      chk("rr_err", o_err, 0);
    end

    // Outstanding limit
    do_reset();
    for (int k = 1; k <= 4; k++) load_ok(5'(k), "cap_ld");
    set_load(9);
    #1;
    chk("cap_full", o_issue_stall, 1);
    tick();
    idle();
    i_issue_vld = 1; i_issue_rd = 10; i_issue_wr = 1;
    i_issue_rs1 = 11; i_issue_rs2 = 12;
    i_issue_use_rs1 = 1; i_issue_use_rs2 = 1;
    #1;
    chk("cap_alu", o_issue_stall, 0);
    tick();
    idle();
    set_load(9);
    i_lsu_vld = 1; i_lsu_addr = 1; i_lsu_data = 32'h77;
    #1;
    chk("cap_k0", o_issue_stall, 1);
    tick();
    i_lsu_vld = 0;
    #1;
    chk("cap_k1", o_issue_stall, 1);
    tick();
    chk("cap_k2", o_issue_stall, 0);
    tick();
    set_load(13);
    #1;
    chk("cap_refull", o_issue_stall, 1);
    chk("cap_pend", o_pending, 32'h21c);
    idle();
    tick();

    // Stray LSU write sets sticky error; EX write to x0
    do_reset();
    i_lsu_vld = 1; i_lsu_addr = 20; i_lsu_data = 32'h55;
    #1;
    chk("err_rdy", o_lsu_rdy, 1);
    tick();
    idle();
    #1;
    chk("err_wren", o_rd_wren, 1);
    chk("err_addr", o_rd_addr, 20);
    tick();
    chk("err_set", o_err, 1);
    i_ex_vld = 1; i_ex_addr = 0; i_ex_data = 32'h99;
    #1;
    chk("x0_rdy", o_ex_rdy, 1);
    tick();
    idle();
    #1;
    chk("x0_wren", o_rd_wren, 0);
    tick();
    tick();
    chk("err_sticky", o_err, 1);
    do_reset();
    chk("err_clr", o_err, 0);

    // Reset mid-operation
    load_ok(3, "mr_ld3");
    load_ok(4, "mr_ld4");
    chk("mr_pend", o_pending, 32'h18);
    i_lsu_vld = 1; i_lsu_addr = 3; i_lsu_data = 32'h1;
    i_rst_n = 0;
    tick();
    i_rst_n = 1;
    idle();
    #1;
    chk("mr_pend0", o_pending, 0);
    chk("mr_wren0", o_rd_wren, 0);
    tick();
    chk("mr_wren1", o_rd_wren, 0);
    load_ok(3, "mr_ld3b");
    load_ok(5, "mr_ld5");
    load_ok(6, "mr_ld6");
    load_ok(7, "mr_ld7");
    set_load(9);
    #1;
    chk("mr_full", o_issue_stall, 1);
    chk("mr_pend2", o_pending, 32'hE8);
    idle();

    // Random run against the model
    do_reset();
    for (int k = 0; k < 32; k++) m_pend[k] = 0;
    m_cnt = 0; m_pref_lsu = 0; m_wv = 0; m_wl = 0;
    m_wa = 0; m_wd = 0; m_err = 0;
    avail.delete();
    begin
      bit ex_hold;
      bit ls_hold;
      ex_hold = 0;
      ls_hold = 0;
      for (int c = 0; c < 3000; c++) begin
        bit st;
        bit gex;
        bit gls;
        chk("r_wren", o_rd_wren, m_wv);
        chk("r_addr", o_rd_addr, m_wa);
        chk("r_data", o_rd_data, m_wd);
        chk("r_pend", o_pending, m_pend_vec());
        chk("r_err", o_err, m_err);
        if (!ex_hold) begin
          i_ex_vld = ($urandom_range(0, 2) == 0);
          i_ex_addr = 5'($urandom_range(0, 31));
          i_ex_data = $urandom;
        end
        if (!ls_hold) begin
          i_lsu_vld = 0;
          if (avail.size() > 0 && $urandom_range(0, 2) == 0) begin
            int ix;
            ix = $urandom_range(0, avail.size() - 1);
            i_lsu_vld = 1;
            i_lsu_addr = 5'(avail[ix]);
            i_lsu_data = $urandom;
            avail.delete(ix);
          end
        end
        i_issue_vld = $urandom_range(0, 1);
        i_issue_rs1 = 5'($urandom_range(0, 15));
        i_issue_rs2 = 5'($urandom_range(0, 15));
        i_issue_use_rs1 = $urandom_range(0, 1);
        i_issue_use_rs2 = $urandom_range(0, 1);
        i_issue_rd = 5'($urandom_range(0, 15));
        i_issue_wr = ($urandom_range(0, 3) != 0);
        i_issue_is_load = $urandom_range(0, 1);
        #1;
        st = m_stall();
        if (i_ex_vld && i_lsu_vld) begin
          gex = !m_pref_lsu;
          gls = m_pref_lsu;
        end else begin
          gex = i_ex_vld;
          gls = i_lsu_vld;
        end
        chk("r_stall", o_issue_stall, st);
        chk("r_exrdy", o_ex_rdy, gex);
        chk("r_lsrdy", o_lsu_rdy, gls);
        if (m_wv && m_wl) begin
          if (!m_pend[m_wa] || m_cnt == 0) m_err = 1;
          else m_cnt--;
          m_pend[m_wa] = 0;
        end
        if (i_issue_vld && !st && i_issue_is_load && i_issue_wr
            && i_issue_rd != 0) begin
          m_pend[i_issue_rd] = 1;
          m_cnt++;
          avail.push_back(int'(i_issue_rd));
        end
        if (gex || gls) begin
          m_wa = gls ? i_lsu_addr : i_ex_addr;
          m_wd = gls ? i_lsu_data : i_ex_data;
          m_wv = (m_wa != 0);
          m_wl = gls && (m_wa != 0);
        end else begin
          m_wv = 0;
          m_wl = 0;
        end
        if (i_ex_vld && i_lsu_vld) m_pref_lsu = !m_pref_lsu;
        ex_hold = i_ex_vld && !gex;
        ls_hold = i_lsu_vld && !gls;
        tick();
      end
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Sequences the single write port of the 32x32 register file (x0 hardwired zero) between two writeback sources.
  - EX: single-cycle ALU results.
  - LSU: SRAM load returns, multi-cycle, may complete out of issue order.
- Keeps a scoreboard of registers with outstanding loads and stalls issue on RAW/WAW hazards against them.
- Sits between decode/issue, EX, LSU and the register file.

Parameters:
- MAX_OUTSTANDING, 4, maximum loads in flight (1..31); issue of a further load stalls when reached.
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding-load counter.

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_rst_n  in  1  synchronous reset, active low.
- i_issue_vld  in  1  decode presents an instruction this cycle.
- i_issue_rs1  in  5  source register 1 address.
- i_issue_rs2  in  5  source register 2 address.
- i_issue_use_rs1  in  1  instruction reads rs1.
- i_issue_use_rs2  in  1  instruction reads rs2.
- i_issue_rd  in  5  destination register address.
- i_issue_wr  in  1  instruction writes rd.
- i_issue_is_load  in  1  instruction is a load (rd written later by LSU).
- o_issue_stall  out  1  issue must hold; combinational.
- i_ex_vld  in  1  EX writeback request.
- i_ex_addr  in  5  EX destination register.
- i_ex_data  in  32  EX result.
- o_ex_rdy  out  1  EX request accepted this cycle; combinational.
- i_lsu_vld  in  1  LSU writeback request.
- i_lsu_addr  in  5  LSU destination register.
- i_lsu_data  in  32  load data.
- o_lsu_rdy  out  1  LSU request accepted this cycle; combinational.
- o_rd_wren  out  1  register file write enable; registered.
- o_rd_addr  out  5  register file write address; registered.
- o_rd_data  out  32  register file write data; registered.
- o_pending  out  32  scoreboard, bit n = load to xn outstanding; bit 0 always 0.
- o_err  out  1  sticky: LSU wrote a register with no pending bit, or counter underflow.

Behaviour:
- Reset (i_rst_n=0 at edge):
  - o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_pending=0, o_err=0.
  - Outstanding count=0; round-robin pointer = EX-preferred.
  - Reset mid-operation discards all in-flight state; no write issued in the following cycle.
- Arbitration (combinational, cycle N):
  - Only one source valid: it is granted.
  - Both valid: round-robin. Pointer toggles to the other source after each contested grant. Uncontested grants leave the pointer unchanged.
  - Source not granted holds vld/addr/data stable until its rdy is seen.
- Write port:
  - Grant in cycle N registers addr/data; o_rd_wren=1 during cycle N+1; regfile commits at end of N+1.
  - Granted request with addr=0 is consumed (rdy=1) but o_rd_wren stays 0.
  - No grant: o_rd_wren=0; o_rd_addr/o_rd_data hold their previous values.
- Scoreboard:
  - Load issue accepted (i_issue_vld & ~o_issue_stall & i_issue_is_load & i_issue_wr & rd!=0) sets pending[rd] and increments count at that edge.
  - Pending bit clears and count decrements at the edge ending cycle N+1, i.e. when the LSU write commits. The bit reads 0 from cycle N+2. There is no bypass.
  - Load issue and LSU commit at the same edge: count unchanged; both bit updates apply.
  - Load to x0 neither sets a bit nor counts.
  - LSU commit with pending[addr]=0, or count=0 with addr!=0: o_err set sticky, count not decremented.
- Stall (combinational): o_issue_stall = i_issue_vld & any of:
  - use_rs1 & pending[rs1];
  - use_rs2 & pending[rs2];
  - wr & pending[rd];
  - is_load & count==MAX_OUTSTANDING.
  - Address 0 never matches.
- EX writes never touch the scoreboard. WAW stall guarantees EX never targets a pending register.

Test Plan:
- Reset, then EX-only write x5=0xDEADBEEF in cycle 2 → o_rd_wren=1, o_rd_addr=5, o_rd_data=0xDEADBEEF in cycle 3; o_pending=0.
- Issue load rd=x7; next cycle issue add with rs1=x7 → o_pending[7]=1 and o_issue_stall=1. LSU returns x7=0x12 in cycle K → write in K+1, o_pending[7]=0 at K+2, stall drops at K+2.
- EX and LSU both valid for 4 cycles (x1..x4 / pending x8..x11) → grants alternate EX, LSU, EX, LSU starting with EX; no beat lost or duplicated.
- Issue 4 loads to x1..x4 (MAX_OUTSTANDING=4), fifth load rd=x9 → stall=1. Non-load add x10,x11,x12 → no stall. First LSU commit → fifth load issues, count returns to 4.
- LSU write to x20 with nothing pending → write performed, o_err=1 and stays 1 until reset. EX write to x0 → o_ex_rdy=1, o_rd_wren=0.
- Loads to x3 and x4 outstanding, assert i_rst_n=0 one cycle → o_pending=0, count=0, o_rd_wren=0 next cycle; load to x3 then issues without stall.
